// File: rtl/led_cube_pkg.sv
// Shared types and defaults for the LED cube layer scanner.
package led_cube_pkg;

   localparam int LAYERS_DEF = 4;
   localparam int COLS_DEF   = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BLANK = 2'd1,
      DRIVE = 2'd2
   } scan_state_t;

endpackage

// File: rtl/edge_sync.sv
// Synchronizes an asynchronous square wave and emits a registered 1-cycle
// pulse on each of its rising edges.
module edge_sync #(
   parameter int STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic async_i,
   output logic rise_o
);

   logic [STAGES-1:0] sync_q;
   logic              prev_q;
   logic              rise_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_q <= '0;
         prev_q <= 1'b0;
         rise_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], async_i};
         prev_q <= sync_q[STAGES-1];
         rise_q <= sync_q[STAGES-1] & ~prev_q;
      end
   end

   assign rise_o = rise_q;

endmodule

// File: rtl/led_cube_layer_scanner.sv
// Layer-multiplexed LED cube driver with a double-buffered frame store;
// buffer swaps happen only when layer 0 is entered, and layers are blanked between drives.
module led_cube_layer_scanner
   import led_cube_pkg::*;
#(
   parameter int LAYERS       = LAYERS_DEF,
   parameter int COLS         = COLS_DEF,
   parameter int BLANK_CYCLES = 500,
   parameter int SYNC_STAGES  = 2
) (
   input  logic                      clk_50MHz,
   input  logic                      reset,
   input  logic                      refresh_clk,
   input  logic                      enable,
   input  logic                      wr_en,
   input  logic [$clog2(LAYERS)-1:0] wr_layer,
   input  logic [COLS-1:0]           wr_data,
   input  logic                      swap_req,
   output logic                      swap_ack,
   output logic                      frame_start,
   output logic [LAYERS-1:0]         layer_sel,
   output logic [COLS-1:0]           col_data
);

   localparam int LW = $clog2(LAYERS);
   localparam int CW = $clog2(BLANK_CYCLES + 1);

   scan_state_t       state_q, state_d;
   logic [LW-1:0]     idx_q, idx_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              pending_q, pending_d;
   logic              front_sel_q;
   logic [LAYERS-1:0] layer_sel_q, layer_sel_d;
   logic [COLS-1:0]   col_q, col_d;
   logic              swap_ack_q, swap_ack_d;
   logic              frame_start_q, frame_start_d;
   logic              tick;
   logic              boundary;
   logic              do_swap;
   logic [COLS-1:0]   front_row;
   logic [LAYERS-1:0] wr_hit;

   logic [COLS-1:0]   buf_a_q [LAYERS];
   logic [COLS-1:0]   buf_b_q [LAYERS];

   edge_sync #(
      .STAGES (SYNC_STAGES)
   ) u_edge_sync (
      .clk_i   (clk_50MHz),
      .rst_i   (reset),
      .async_i (refresh_clk),
      .rise_o  (tick)
   );

   // Out-of-range row addresses match no row and are silently dropped.
   for (genvar gi = 0; gi < LAYERS; gi++) begin : g_wr_hit
      assign wr_hit[gi] = wr_en && (wr_layer == LW'(gi));
   end

   always_ff @(posedge clk_50MHz) begin
      if (reset) begin
         state_q       <= IDLE;
         idx_q         <= '0;
         cnt_q         <= '0;
         pending_q     <= 1'b0;
         front_sel_q   <= 1'b0;
         layer_sel_q   <= '0;
         col_q         <= '0;
         swap_ack_q    <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         cnt_q         <= cnt_d;
         pending_q     <= pending_d;
         front_sel_q   <= front_sel_q ^ do_swap;
         layer_sel_q   <= layer_sel_d;
         col_q         <= col_d;
         swap_ack_q    <= swap_ack_d;
         frame_start_q <= frame_start_d;
      end
   end

   // front_sel_q = 0 means buf_a is displayed, so writes land in buf_b.
   always_ff @(posedge clk_50MHz) begin
      if (reset) begin
         for (int r = 0; r < LAYERS; r++) begin
            buf_a_q[r] <= '0;
            buf_b_q[r] <= '0;
         end
      end else begin
         for (int r = 0; r < LAYERS; r++) begin
            if (wr_hit[r] && front_sel_q)  buf_a_q[r] <= wr_data;
            if (wr_hit[r] && !front_sel_q) buf_b_q[r] <= wr_data;
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      cnt_d    = cnt_q;
      boundary = 1'b0;
      if (!enable) begin
         state_d = IDLE;
         idx_d   = '0;
         cnt_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (tick) begin
                  state_d  = BLANK;
                  idx_d    = '0;
                  cnt_d    = '0;
                  boundary = 1'b1;
               end
            end
            BLANK: begin
               if (cnt_q == CW'(BLANK_CYCLES - 1)) begin
                  state_d = DRIVE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            DRIVE: begin
               if (tick) begin
                  state_d = BLANK;
                  cnt_d   = '0;
                  if (idx_q == LW'(LAYERS - 1)) begin
                     idx_d    = '0;
                     boundary = 1'b1;
                  end else begin
                     idx_d = idx_q + LW'(1);
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
      // A request arriving on the boundary itself is consumed by that swap.
      do_swap   = boundary && (pending_q || swap_req);
      pending_d = boundary ? 1'b0 : (pending_q || swap_req);
   end

   always_comb begin
      front_row     = front_sel_q ? buf_b_q[idx_d] : buf_a_q[idx_d];
      layer_sel_d   = '0;
      col_d         = '0;
      swap_ack_d    = do_swap;
      frame_start_d = boundary;
      if (state_d == DRIVE) begin
         if (state_q == DRIVE) begin
            layer_sel_d = layer_sel_q;
            col_d       = col_q;
         end else begin
            layer_sel_d = LAYERS'(1) << idx_d;
            col_d       = front_row;
         end
      end
   end

   assign swap_ack    = swap_ack_q;
   assign frame_start = frame_start_q;
   assign layer_sel   = layer_sel_q;
   assign col_data    = col_q;

endmodule

// File: tb/tb_led_cube_layer_scanner.sv
// Directed bench for the LED cube layer scanner (BLANK_CYCLES=4, 40-clock refresh period).
module tb_led_cube_layer_scanner;

   logic        clk_50MHz;
   logic        reset;
   logic        refresh_clk;
   logic        enable;
   logic        wr_en;
   logic [1:0]  wr_layer;
   logic [15:0] wr_data;
   logic        swap_req;
   logic        swap_ack;
   logic        frame_start;
   logic [3:0]  layer_sel;
   logic [15:0] col_data;

   int          checks   = 0;
   int          failures = 0;
   int          cyc      = 0;
   string       tag      = "init";
   logic [3:0]  cur_ls   = 4'b0;
   logic [15:0] cur_col  = 16'h0;

   led_cube_layer_scanner #(
      .LAYERS       (4),
      .COLS         (16),
      .BLANK_CYCLES (4),
      .SYNC_STAGES  (2)
   ) dut (
      .clk_50MHz   (clk_50MHz),
      .reset       (reset),
      .refresh_clk (refresh_clk),
      .enable      (enable),
      .wr_en       (wr_en),
      .wr_layer    (wr_layer),
      .wr_data     (wr_data),
      .swap_req    (swap_req),
      .swap_ack    (swap_ack),
      .frame_start (frame_start),
      .layer_sel   (layer_sel),
      .col_data    (col_data)
   );

   initial clk_50MHz = 1'b0;
   always #5 clk_50MHz = ~clk_50MHz;

   task automatic step();
      @(posedge clk_50MHz);
      #1;
      cyc++;
   endtask

   task automatic expect_out(input logic [3:0] ls, input logic [15:0] col,
                             input logic fs, input logic ack);
      logic [21:0] obs;
      logic [21:0] exp;
      obs = {layer_sel, col_data, frame_start, swap_ack};
      exp = {ls, col, fs, ack};
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s cyc=%0d observed ls=%b col=%h fs=%b ack=%b expected ls=%b col=%h fs=%b ack=%b",
                tag, cyc, layer_sel, col_data, frame_start, swap_ack, ls, col, fs, ack);
      end
   endtask

   task automatic write_row(input logic [1:0] row, input logic [15:0] data);
      wr_en    = 1'b1;
      wr_layer = row;
      wr_data  = data;
      step();
      wr_en    = 1'b0;
   endtask

   task automatic pulse_req();
      swap_req = 1'b1;
      step();
      swap_req = 1'b0;
   endtask

   // One refresh period: tick reaches the FSM 4 clocks after the rise, then 4 blank cycles.
   task automatic advance(input logic [3:0] ls, input logic [15:0] col, input logic fs,
                          input logic ack, input bit req_b, input bit glitch);
      refresh_clk = 1'b1;
      for (int c = 1; c <= 40; c++) begin
         step();
         if (c <= 3)      expect_out(cur_ls, cur_col, 1'b0, 1'b0);
         else if (c == 4) expect_out(4'b0, 16'h0, fs, ack);
         else if (c <= 7) expect_out(4'b0, 16'h0, 1'b0, 1'b0);
         else             expect_out(ls, col, 1'b0, 1'b0);
         if (glitch && c == 2) refresh_clk = 1'b0;
         if (glitch && c == 3) refresh_clk = 1'b1;
         if (req_b && c == 3)  swap_req = 1'b1;
         if (c == 4)           swap_req = 1'b0;
         if (c == 20)          refresh_clk = 1'b0;
      end
      cur_ls  = ls;
      cur_col = col;
      $display("[%s] layer_sel=%b col_data=%h fs_exp=%b ack_exp=%b", tag, ls, col, fs, ack);
   endtask

   task automatic frame(input logic ack, input bit req_b, input logic [15:0] r0,
                        input logic [15:0] r1, input logic [15:0] r2, input logic [15:0] r3);
      advance(4'b0001, r0, 1'b1, ack, req_b, 1'b0);
      advance(4'b0010, r1, 1'b0, 1'b0, 1'b0, 1'b0);
      advance(4'b0100, r2, 1'b0, 1'b0, 1'b0, 1'b0);
      advance(4'b1000, r3, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      reset       = 1'b1;
      refresh_clk = 1'b0;
      enable      = 1'b0;
      wr_en       = 1'b0;
      wr_layer    = 2'd0;
      wr_data     = 16'h0;
      swap_req    = 1'b0;
      repeat (3) step();
      tag = "reset_state";
      expect_out(4'b0, 16'h0, 1'b0, 1'b0);
      reset = 1'b0;
      step();
      expect_out(4'b0, 16'h0, 1'b0, 1'b0);

      // Test 1: reach DRIVE at layer 2, then reset; both buffers must come back empty.
      tag = "t1_fill";
      write_row(2'd0, 16'h1111);
      write_row(2'd1, 16'h2222);
      write_row(2'd2, 16'h3333);
      write_row(2'd3, 16'h4444);
      pulse_req();
      enable = 1'b1;
      advance(4'b0001, 16'h1111, 1'b1, 1'b1, 1'b0, 1'b0);
      advance(4'b0010, 16'h2222, 1'b0, 1'b0, 1'b0, 1'b0);
      advance(4'b0100, 16'h3333, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int r = 0; r < 4; r++) write_row(2'(r), 16'hBEEF);
      tag = "t1_reset";
      reset = 1'b1;
      step();
      expect_out(4'b0, 16'h0, 1'b0, 1'b0);
      reset = 1'b0;
      step();
      expect_out(4'b0, 16'h0, 1'b0, 1'b0);
      cur_ls  = 4'b0;
      cur_col = 16'h0;
      tag = "t1_front_cleared";
      frame(1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
      pulse_req();
      tag = "t1_back_cleared";
      frame(1'b1, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0);

      // Test 2: load a pattern, request swap, then start scanning.
      tag = "t2_disable";
      enable = 1'b0;
      step();
      expect_out(4'b0, 16'h0, 1'b0, 1'b0);
      cur_ls  = 4'b0;
      cur_col = 16'h0;
      write_row(2'd0, 16'h0001);
      write_row(2'd1, 16'h0010);
      write_row(2'd2, 16'h0100);
      write_row(2'd3, 16'h1000);
      pulse_req();
      enable = 1'b1;
      tag = "t2_scan";
      frame(1'b1, 1'b0, 16'h0001, 16'h0010, 16'h0100, 16'h1000);

      // Test 3: back-buffer write is invisible until a swap at the next layer-0 boundary.
      tag = "t3_no_swap";
      advance(4'b0001, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0);
      write_row(2'd1, 16'hFFFF);
      advance(4'b0010, 16'h0010, 1'b0, 1'b0, 1'b0, 1'b0);
      advance(4'b0100, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0);
      pulse_req();
      tag = "t3_pending";
      advance(4'b1000, 16'h1000, 1'b0, 1'b0, 1'b0, 1'b0);
      tag = "t3_swapped";
      frame(1'b1, 1'b0, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000);

      // Test 4: request exactly on the boundary swaps once only.
      tag = "t4_req_on_boundary";
      frame(1'b1, 1'b1, 16'h0001, 16'h0010, 16'h0100, 16'h1000);
      tag = "t4_no_second_swap";
      frame(1'b0, 1'b0, 16'h0001, 16'h0010, 16'h0100, 16'h1000);

      // Test 5: drop enable during the blank before layer 3.
      tag = "t5_run";
      advance(4'b0001, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0);
      advance(4'b0010, 16'h0010, 1'b0, 1'b0, 1'b0, 1'b0);
      advance(4'b0100, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0);
      tag = "t5_blank_l3";
      refresh_clk = 1'b1;
      for (int c = 1; c <= 3; c++) begin
         step();
         expect_out(4'b0100, 16'h0100, 1'b0, 1'b0);
      end
      step();
      expect_out(4'b0, 16'h0, 1'b0, 1'b0);
      step();
      expect_out(4'b0, 16'h0, 1'b0, 1'b0);
      tag = "t5_disabled";
      enable = 1'b0;
      for (int c = 0; c < 12; c++) begin
         step();
         expect_out(4'b0, 16'h0, 1'b0, 1'b0);
         if (c == 5) refresh_clk = 1'b0;
      end
      refresh_clk = 1'b1;
      for (int c = 0; c < 10; c++) begin
         step();
         expect_out(4'b0, 16'h0, 1'b0, 1'b0);
      end
      refresh_clk = 1'b0;
      repeat (4) step();
      cur_ls  = 4'b0;
      cur_col = 16'h0;
      enable = 1'b1;
      tag = "t5_restart";
      advance(4'b0001, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0);

      // Test 6: a second refresh rise during BLANK is ignored.
      tag = "t6_glitch";
      advance(4'b0010, 16'h0010, 1'b0, 1'b0, 1'b0, 1'b1);
      tag = "t6_next";
      advance(4'b0100, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
